// File: rtl/baby_store_if.sv
// Load-stream and CPU-port bundle for the Baby store loader.
interface baby_store_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              load_start;
  logic              load_clear;
  logic [ADDR_W-1:0] load_base;
  logic              load_valid;
  logic [WIDTH-1:0]  load_data;
  logic              load_last;
  logic              load_ready;
  logic              busy;
  logic              done;
  logic              truncated;
  logic [ADDR_W:0]   words_loaded;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [WIDTH-1:0]  cpu_wdata;
  logic [WIDTH-1:0]  cpu_rdata;
  logic              cpu_stall;

  modport master (
    output load_start, load_clear, load_base, load_valid, load_data, load_last,
    output cpu_addr, cpu_we, cpu_wdata,
    input  load_ready, busy, done, truncated, words_loaded, cpu_rdata, cpu_stall
  );

  modport slave (
    input  load_start, load_clear, load_base, load_valid, load_data, load_last,
    input  cpu_addr, cpu_we, cpu_wdata,
    output load_ready, busy, done, truncated, words_loaded, cpu_rdata, cpu_stall
  );
endinterface

// File: rtl/baby_store_loader.sv
// DEPTH x WIDTH Baby store, loaded at run time from a valid/ready word stream,
// with an optional zero-fill pass and a CPU read/write port stalled during loads.
module baby_store_loader #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned ADDR_W       = $clog2(DEPTH),
  parameter bit          REVERSE_BITS = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  baby_store_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [ADDR_W:0]   words_loaded_q;
  logic              truncated_q;
  logic              load_ready_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  cpu_rdata_q;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              accept_c;
  logic              end_c;
  logic              cpu_side_c;
  logic [WIDTH-1:0]  load_word_c;

  assign accept_c   = (state_q == LOAD) && bus.load_valid;
  assign end_c      = accept_c && (bus.load_last || (ptr_q == LAST_ADDR));
  assign cpu_side_c = (state_q == IDLE) || (state_q == DONE);

  // SNP order is LSB-first, so optionally mirror the word on the way in
  always_comb begin
    load_word_c = bus.load_data;
    if (REVERSE_BITS) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        load_word_c[i] = bus.load_data[WIDTH-1-i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.load_start) state_d = bus.load_clear ? CLEAR : LOAD;
      CLEAR:   if (clr_ptr_q == LAST_ADDR) state_d = LOAD;
      LOAD:    if (end_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track it exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      clr_ptr_q      <= '0;
      words_loaded_q <= '0;
      truncated_q    <= 1'b0;
      load_ready_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cpu_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      load_ready_q <= (state_d == LOAD);
      busy_q       <= (state_d == CLEAR) || (state_d == LOAD);
      done_q       <= (state_d == DONE);

      if ((state_q == IDLE) && bus.load_start) begin
        ptr_q          <= bus.load_base;
        clr_ptr_q      <= '0;
        words_loaded_q <= '0;
        truncated_q    <= 1'b0;
      end

      if (state_q == CLEAR) clr_ptr_q <= clr_ptr_q + ADDR_W'(1);

      if (accept_c) begin
        ptr_q          <= ptr_q + ADDR_W'(1);
        words_loaded_q <= words_loaded_q + (ADDR_W+1)'(1);
        if ((ptr_q == LAST_ADDR) && !bus.load_last) truncated_q <= 1'b1;
      end

      if (cpu_side_c) cpu_rdata_q <= mem[bus.cpu_addr];
    end
  end

  // Store array: not reset; one writer per state, none while reset is held
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (cpu_side_c && bus.cpu_we)  mem[bus.cpu_addr] <= bus.cpu_wdata;
      else if (state_q == CLEAR)     mem[clr_ptr_q]    <= '0;
      else if (accept_c)             mem[ptr_q]        <= load_word_c;
    end
  end

  assign bus.load_ready   = load_ready_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.truncated    = truncated_q;
  assign bus.words_loaded = words_loaded_q;
  assign bus.cpu_rdata    = cpu_rdata_q;
  assign bus.cpu_stall    = busy_q;

endmodule

// File: tb/tb_baby_store_loader.sv
// Directed bench for baby_store_loader: bit-reversing instance a, raw instance b.
module tb_baby_store_loader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  baby_store_if #(.WIDTH(32), .ADDR_W(5)) ba ();
  baby_store_if #(.WIDTH(32), .ADDR_W(5)) bb ();

  baby_store_loader #(.WIDTH(32), .DEPTH(32), .REVERSE_BITS(1'b1)) u_rev (
    .clk(clk), .reset(reset), .bus(ba));
  baby_store_loader #(.WIDTH(32), .DEPTH(32), .REVERSE_BITS(1'b0)) u_raw (
    .clk(clk), .reset(reset), .bus(bb));

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_read(input logic [4:0] addr, output logic [31:0] data);
    ba.cpu_addr = addr;
    ba.cpu_we   = 1'b0;
    tick();
    data = ba.cpu_rdata;
  endtask

  task automatic a_write(input logic [4:0] addr, input logic [31:0] data);
    ba.cpu_addr  = addr;
    ba.cpu_wdata = data;
    ba.cpu_we    = 1'b1;
    tick();
    ba.cpu_we    = 1'b0;
  endtask

  task automatic b_read(input logic [4:0] addr, output logic [31:0] data);
    bb.cpu_addr = addr;
    bb.cpu_we   = 1'b0;
    tick();
    data = bb.cpu_rdata;
  endtask

  task automatic a_start(input logic clr, input logic [4:0] base);
    ba.load_start = 1'b1;
    ba.load_clear = clr;
    ba.load_base  = base;
    tick();
    ba.load_start = 1'b0;
    ba.load_clear = 1'b0;
  endtask

  task automatic a_beat(input logic [31:0] data, input logic last, output logic acc);
    ba.load_valid = 1'b1;
    ba.load_data  = data;
    ba.load_last  = last;
    acc = ba.load_ready;
    tick();
    ba.load_valid = 1'b0;
    ba.load_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    exp_t        e;
    logic [31:0] d;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a_read(e.addr, d);
      chk($sformatf("%s_mem%0d", tag, e.addr), 64'(d), 64'(e.data));
    end
  endtask

  initial begin
    logic        acc;
    logic [31:0] d;
    int          n;
    logic [4:0]  vpat;

    reset = 1'b1;
    ba.load_start = 0; ba.load_clear = 0; ba.load_base = '0; ba.load_valid = 0;
    ba.load_data = '0; ba.load_last = 0; ba.cpu_addr = '0; ba.cpu_we = 0; ba.cpu_wdata = '0;
    bb.load_start = 0; bb.load_clear = 0; bb.load_base = '0; bb.load_valid = 0;
    bb.load_data = '0; bb.load_last = 0; bb.cpu_addr = '0; bb.cpu_we = 0; bb.cpu_wdata = '0;
    tick(); tick();
    chk("rst_ready", 64'(ba.load_ready), 64'(0));
    chk("rst_busy", 64'(ba.busy), 64'(0));
    chk("rst_done", 64'(ba.done), 64'(0));
    chk("rst_trunc", 64'(ba.truncated), 64'(0));
    chk("rst_words", 64'(ba.words_loaded), 64'(0));
    chk("rst_rdata", 64'(ba.cpu_rdata), 64'(0));
    chk("rst_stall", 64'(ba.cpu_stall), 64'(0));
    chk("rst_b_busy", 64'(bb.busy), 64'(0));
    reset = 1'b0;
    tick();

    // 1: bit reversal
    a_start(1'b0, 5'd0);
    chk("t1_ready", 64'(ba.load_ready), 64'(1));
    a_beat(32'hE8000000, 1'b0, acc); sb.push_back('{5'd0, 32'h00000017});
    a_beat(32'h48010000, 1'b1, acc); sb.push_back('{5'd1, 32'h00008012});
    chk("t1_done_pulse", 64'(ba.done), 64'(1));
    chk("t1_ready_drop", 64'(ba.load_ready), 64'(0));
    tick();
    chk("t1_done_single", 64'(ba.done), 64'(0));
    chk("t1_words", 64'(ba.words_loaded), 64'(2));
    chk("t1_trunc", 64'(ba.truncated), 64'(0));
    drain("t1");

    // 2: clear then load
    a_write(5'd5, 32'hDEADBEEF);
    a_start(1'b1, 5'd3);
    n = 0;
    while (!ba.load_ready && n < 100) begin
      if (ba.busy) n++;
      tick();
    end
    chk("t2_clear_cycles", 64'(n), 64'(32));
    a_beat(32'h00000001, 1'b1, acc);
    sb.push_back('{5'd3, 32'h80000000});
    sb.push_back('{5'd5, 32'h00000000});
    sb.push_back('{5'd4, 32'h00000000});
    tick();
    drain("t2");

    // 3: truncation at store end
    a_write(5'd0, 32'hA5A5A5A5);
    a_start(1'b0, 5'd30);
    a_beat(32'h00000001, 1'b0, acc); chk("t3_acc1", 64'(acc), 64'(1));
    a_beat(32'h00000002, 1'b0, acc); chk("t3_acc2", 64'(acc), 64'(1));
    chk("t3_ready_drop", 64'(ba.load_ready), 64'(0));
    chk("t3_done", 64'(ba.done), 64'(1));
    a_beat(32'h00000003, 1'b0, acc); chk("t3_acc3", 64'(acc), 64'(0));
    a_beat(32'h00000004, 1'b0, acc); chk("t3_acc4", 64'(acc), 64'(0));
    chk("t3_trunc", 64'(ba.truncated), 64'(1));
    chk("t3_words", 64'(ba.words_loaded), 64'(2));
    sb.push_back('{5'd30, 32'h80000000});
    sb.push_back('{5'd31, 32'h40000000});
    sb.push_back('{5'd0, 32'hA5A5A5A5});
    drain("t3");

    // 4: handshake stalls on the raw instance
    bb.cpu_addr = 5'd13; bb.cpu_wdata = 32'hCAFEF00D; bb.cpu_we = 1'b1;
    tick();
    bb.cpu_we = 1'b0;
    bb.load_start = 1'b1; bb.load_base = 5'd10;
    tick();
    bb.load_start = 1'b0;
    vpat = 5'b11001;
    for (int i = 0; i < 5; i++) begin
      bb.load_valid = vpat[i];
      bb.load_data  = 32'h11111111 * 32'(i + 1);
      bb.load_last  = (i == 4);
      tick();
      chk($sformatf("t4_done_c%0d", i), 64'(bb.done), 64'(i == 4));
    end
    bb.load_valid = 1'b0; bb.load_last = 1'b0;
    tick();
    chk("t4_words", 64'(bb.words_loaded), 64'(3));
    b_read(5'd10, d); chk("t4_mem10", 64'(d), 64'(32'h11111111));
    b_read(5'd11, d); chk("t4_mem11", 64'(d), 64'(32'h44444444));
    b_read(5'd12, d); chk("t4_mem12", 64'(d), 64'(32'h55555555));
    b_read(5'd13, d); chk("t4_mem13", 64'(d), 64'(32'hCAFEF00D));

    // 5: CPU blocked while busy, effective in IDLE
    a_write(5'd7, 32'h0BADF00D);
    a_read(5'd7, d);
    chk("t5_pre", 64'(d), 64'(32'h0BADF00D));
    a_start(1'b0, 5'd20);
    ba.cpu_addr = 5'd7; ba.cpu_wdata = 32'h12345678; ba.cpu_we = 1'b1;
    tick(); tick();
    ba.cpu_addr = 5'd3;
    tick();
    chk("t5_stall", 64'(ba.cpu_stall), 64'(1));
    chk("t5_frozen", 64'(ba.cpu_rdata), 64'(32'h0BADF00D));
    ba.cpu_we = 1'b0; ba.cpu_addr = 5'd7;
    a_beat(32'h00000009, 1'b1, acc);
    sb.push_back('{5'd20, 32'h90000000});
    tick();
    drain("t5");
    a_read(5'd7, d);
    chk("t5_blocked", 64'(d), 64'(32'h0BADF00D));
    ba.cpu_addr = 5'd7; ba.cpu_wdata = 32'h12345678; ba.cpu_we = 1'b1;
    tick();
    ba.cpu_we = 1'b0;
    chk("t5_rbw", 64'(ba.cpu_rdata), 64'(32'h0BADF00D));
    tick();
    chk("t5_written", 64'(ba.cpu_rdata), 64'(32'h12345678));

    // 6: reset mid-LOAD, then start during CLEAR
    a_start(1'b0, 5'd8);
    a_beat(32'h00000003, 1'b0, acc); sb.push_back('{5'd8, 32'hC0000000});
    a_beat(32'h00000005, 1'b0, acc); sb.push_back('{5'd9, 32'hA0000000});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_ready", 64'(ba.load_ready), 64'(0));
    chk("t6_rst_busy", 64'(ba.busy), 64'(0));
    chk("t6_rst_words", 64'(ba.words_loaded), 64'(0));
    chk("t6_rst_done", 64'(ba.done), 64'(0));
    tick();
    chk("t6_no_done", 64'(ba.done), 64'(0));
    drain("t6a");
    a_start(1'b1, 5'd0);
    n = 0;
    while (!ba.load_ready && n < 100) begin
      if (ba.busy) n++;
      if (n == 5) begin
        ba.load_start = 1'b1; ba.load_base = 5'd4;
      end else begin
        ba.load_start = 1'b0;
      end
      tick();
    end
    ba.load_start = 1'b0;
    chk("t6_clear_cycles", 64'(n), 64'(32));
    a_beat(32'h00000007, 1'b1, acc);
    tick();
    chk("t6_words", 64'(ba.words_loaded), 64'(1));
    sb.push_back('{5'd0, 32'hE0000000});
    sb.push_back('{5'd4, 32'h00000000});
    drain("t6b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
